// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle fetch/execute control FSM driving the picoMIPS PC, IR, register file and multiplier.
module fetch_sequencer #(
  parameter int Psize      = 5,
  parameter int MulTimeout = 15,
  parameter int Csize      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [Psize-1:0] pc_in,
  input  logic [2:0]       opcode,
  input  logic [Psize-1:0] branch_target,
  input  logic             zero,
  input  logic             mul_done,
  output logic             PCup,
  output logic [Psize-1:0] BranchAddress,
  output logic             ir_load,
  output logic             reg_we,
  output logic             mul_start,
  output logic             busy,
  output logic             halted,
  output logic             error,
  output logic [Csize-1:0] retired
);
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MULW, HALTED} state_t;
  state_t state_q, state_d;
  logic [7:0] tmo_q, tmo_d;
  logic error_q, error_d;
  logic [Csize-1:0] retired_q, retired_d;
  logic inc;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= IDLE;
      tmo_q     <= '0;
      error_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      error_q   <= error_d;
      retired_q <= retired_d;
    end
  // The PC has no enable, so "hold" means reloading pc_in every idle cycle.
  always_comb begin
    state_d       = state_q;
    tmo_d         = tmo_q;
    error_d       = error_q;
    retired_d     = retired_q;
    PCup          = 1'b0;
    BranchAddress = pc_in;
    ir_load       = 1'b0;
    reg_we        = 1'b0;
    mul_start     = 1'b0;
    inc           = 1'b0;
    case (state_q)
      IDLE: begin
        BranchAddress = '0;
        if (start) begin
          state_d   = FETCH;
          retired_d = '0;
        end
      end
      FETCH: begin
        ir_load = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        state_d = FETCH;
        inc     = 1'b1;
        case (opcode)
          3'b001, 3'b010: begin
            reg_we = 1'b1;
            PCup   = 1'b1;
          end
          3'b011: begin
            mul_start = 1'b1;
            tmo_d     = '0;
            state_d   = MULW;
            inc       = 1'b0;
          end
          3'b100: begin
            PCup          = !zero;
            BranchAddress = zero ? branch_target : pc_in;
          end
          3'b101: BranchAddress = branch_target;
          3'b111: state_d = HALTED;
          default: PCup = 1'b1;
        endcase
      end
      MULW: begin
        if (mul_done) begin
          reg_we  = 1'b1;
          PCup    = 1'b1;
          state_d = FETCH;
          inc     = 1'b1;
        end else if (tmo_q == 8'(MulTimeout - 1)) begin
          error_d = 1'b1;
          state_d = HALTED;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      HALTED: begin
        if (start) begin
          BranchAddress = '0;
          error_d       = 1'b0;
          retired_d     = '0;
          state_d       = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
    if (inc && retired_q != '1) retired_d = retired_q + Csize'(1);
  end
  assign busy    = (state_q == FETCH) || (state_q == EXEC) || (state_q == MULW);
  assign halted  = state_q == HALTED;
  assign error   = error_q;
  assign retired = retired_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed bench with a PC register, IR and program ROM around the sequencer.
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic reset, start, zero, mul_done;
  logic PCup, ir_load, reg_we, mul_start, busy, halted, error;
  logic [4:0] BranchAddress;
  logic [15:0] retired;
  logic [4:0] pc;
  logic [7:0] ir;
  logic [7:0] rom [32];
  int total = 0, bad = 0;
  localparam logic [2:0] NOP = 3'b000, ADD = 3'b001, ADDI = 3'b010, MUL = 3'b011,
                         BEQ = 3'b100, JMP = 3'b101, HLT = 3'b111;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .pc_in(pc), .opcode(ir[7:5]),
    .branch_target(ir[4:0]), .zero(zero), .mul_done(mul_done), .PCup(PCup),
    .BranchAddress(BranchAddress), .ir_load(ir_load), .reg_we(reg_we),
    .mul_start(mul_start), .busy(busy), .halted(halted), .error(error), .retired(retired)
  );

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc <= '0;
      ir <= '0;
    end else begin
      pc <= PCup ? pc + 5'd1 : BranchAddress;
      if (ir_load) ir <= rom[pc];
    end

  function automatic logic [7:0] ins(input logic [2:0] op, input logic [4:0] t);
    return {op, t};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; start = 1'b0; zero = 1'b0; mul_done = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic go;
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; zero = 1'b0; mul_done = 1'b0;
    #1;
    total++;
    if ({busy, halted, error, PCup, ir_load, reg_we, mul_start} !== 7'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000000", {busy, halted, error, PCup, ir_load, reg_we, mul_start});
    end
    total++;
    if (BranchAddress !== 5'd0 || retired !== 16'd0) begin
      bad++; $display("FAIL reset_ba_ret got=%0d/%0d exp=0/0", BranchAddress, retired);
    end
    do_reset();
    tick();
    total++;
    if (busy !== 1'b0 || BranchAddress !== 5'd0 || PCup !== 1'b0) begin
      bad++; $display("FAIL idle_hold got busy=%b ba=%0d pcup=%b exp 0/0/0", busy, BranchAddress, PCup);
    end
    go();
    total++;
    if (ir_load !== 1'b1 || busy !== 1'b1 || pc !== 5'd0) begin
      bad++; $display("FAIL start_fetch got ir_load=%b busy=%b pc=%0d exp 1/1/0", ir_load, busy, pc);
    end
  endtask

  task automatic test_straight;
    int ep [7] = '{0, 0, 1, 1, 2, 2, 3};
    int ew [7] = '{0, 0, 0, 1, 0, 1, 0};
    do_reset();
    rom[0] = ins(NOP, 0); rom[1] = ins(ADD, 0); rom[2] = ins(ADDI, 0);
    go();
    for (int i = 0; i < 7; i++) begin
      total++;
      if (pc !== 5'(ep[i]) || reg_we !== 1'(ew[i])) begin
        bad++; $display("FAIL straight[%0d] got pc=%0d we=%b exp pc=%0d we=%0d", i, pc, reg_we, ep[i], ew[i]);
      end
      if (i < 6) tick();
    end
    total++;
    if (retired !== 16'd3) begin
      bad++; $display("FAIL straight_retired got=%0d exp=3", retired);
    end
  endtask

  task automatic test_branch;
    int ep [9] = '{0, 0, 7, 7, 8, 8, 31, 31, 0};
    int ez [9] = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
    int eu [9] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
    int eb [9] = '{0, 7, 7, 7, 8, 31, 31, 31, 0};
    do_reset();
    rom[0] = ins(BEQ, 7); rom[7] = ins(BEQ, 7); rom[8] = ins(JMP, 31); rom[31] = ins(NOP, 0);
    go();
    for (int i = 0; i < 9; i++) begin
      zero = 1'(ez[i]);
      #1;
      total++;
      if (pc !== 5'(ep[i]) || PCup !== 1'(eu[i]) || BranchAddress !== 5'(eb[i])) begin
        bad++; $display("FAIL branch[%0d] got pc=%0d up=%b ba=%0d exp pc=%0d up=%0d ba=%0d",
                        i, pc, PCup, BranchAddress, ep[i], eu[i], eb[i]);
      end
      if (i < 8) tick();
    end
    zero = 1'b0;
  endtask

  task automatic test_mul;
    int ep [7] = '{0, 0, 0, 0, 0, 0, 1};
    int md [7] = '{1, 0, 0, 0, 0, 1, 0};
    logic [2:0] ex [7] = '{3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 3'b011, 3'b000};
    do_reset();
    rom[0] = ins(MUL, 0); rom[1] = ins(NOP, 0);
    go();
    for (int i = 0; i < 7; i++) begin
      mul_done = 1'(md[i]);
      #1;
      total++;
      if (pc !== 5'(ep[i]) || {mul_start, reg_we, PCup} !== ex[i] || busy !== 1'b1) begin
        bad++; $display("FAIL mul[%0d] got pc=%0d st/we/up=%b busy=%b exp pc=%0d st/we/up=%b busy=1",
                        i, pc, {mul_start, reg_we, PCup}, busy, ep[i], ex[i]);
      end
      if (i < 6) tick();
    end
    mul_done = 1'b0;
    total++;
    if (retired !== 16'd1) begin
      bad++; $display("FAIL mul_retired got=%0d exp=1", retired);
    end
  endtask

  task automatic test_timeout;
    do_reset();
    rom[0] = ins(MUL, 0);
    go();
    tick();
    tick();
    for (int k = 1; k <= 15; k++) begin
      total++;
      if (busy !== 1'b1 || error !== 1'b0 || halted !== 1'b0 || pc !== 5'd0) begin
        bad++; $display("FAIL mulw_wait[%0d] got busy=%b err=%b halt=%b pc=%0d exp 1/0/0/0", k, busy, error, halted, pc);
      end
      tick();
    end
    total++;
    if (halted !== 1'b1 || error !== 1'b1 || busy !== 1'b0 || pc !== 5'd0 || retired !== 16'd0) begin
      bad++; $display("FAIL timeout got halt=%b err=%b busy=%b pc=%0d ret=%0d exp 1/1/0/0/0",
                      halted, error, busy, pc, retired);
    end
    start = 1'b1;
    #1;
    total++;
    if (BranchAddress !== 5'd0 || PCup !== 1'b0) begin
      bad++; $display("FAIL restart_pins got ba=%0d up=%b exp 0/0", BranchAddress, PCup);
    end
    tick();
    start = 1'b0;
    #1;
    total++;
    if (error !== 1'b0 || ir_load !== 1'b1 || pc !== 5'd0 || halted !== 1'b0) begin
      bad++; $display("FAIL restart got err=%b ir_load=%b pc=%0d halt=%b exp 0/1/0/0", error, ir_load, pc, halted);
    end
  endtask

  task automatic test_halt;
    do_reset();
    rom[0] = ins(NOP, 0); rom[1] = ins(HLT, 0); rom[2] = ins(ADD, 0);
    go();
    repeat (4) tick();
    total++;
    if (halted !== 1'b1 || busy !== 1'b0 || retired !== 16'd2 || pc !== 5'd1) begin
      bad++; $display("FAIL halt got halt=%b busy=%b ret=%0d pc=%0d exp 1/0/2/1", halted, busy, retired, pc);
    end
    mul_done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (pc !== 5'd1 || halted !== 1'b1 || reg_we !== 1'b0) begin
        bad++; $display("FAIL halt_hold[%0d] got pc=%0d halt=%b we=%b exp 1/1/0", i, pc, halted, reg_we);
      end
    end
    mul_done = 1'b0;
  endtask

  task automatic test_async_reset;
    do_reset();
    rom[0] = ins(ADD, 0); rom[1] = ins(MUL, 0);
    go();
    repeat (5) tick();
    total++;
    if (busy !== 1'b1 || retired !== 16'd1 || pc !== 5'd1) begin
      bad++; $display("FAIL pre_reset got busy=%b ret=%0d pc=%0d exp 1/1/1", busy, retired, pc);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({busy, halted, error, PCup} !== 4'b0 || BranchAddress !== 5'd0 || retired !== 16'd0) begin
      bad++; $display("FAIL async_reset got flags=%b ba=%0d ret=%0d exp 0000/0/0",
                      {busy, halted, error, PCup}, BranchAddress, retired);
    end
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_straight();
    test_branch();
    test_mul();
    test_timeout();
    test_halt();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle control FSM that drives the program counter of the picoMIPS core. The PC register has no enable: every clock it either increments (PCup=1) or loads BranchAddress (PCup=0). This block sequences fetch and execute, holds the PC during stalls by reloading its current value, resolves branches and jumps, and waits on the multi-cycle multiplier. It sits between the instruction register/decoder and the PC, register file and multiplier.

## Interface
- Psize, 5, PC/address width (up to 32 instructions)
- MulTimeout, 15, max MULW cycles before error; range 1..255
- Csize, 16, retired-instruction counter width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  begin execution from address 0 (sampled in IDLE and HALTED)
- pc_in  in  Psize  current PC value (PCout of PC register)
- opcode  in  3  decoded opcode from IR, valid in EXEC
- branch_target  in  Psize  absolute target from IR, valid in EXEC
- zero  in  1  ALU zero flag, valid in EXEC
- mul_done  in  1  multiplier result ready
- PCup  out  1  1 = increment PC, 0 = load BranchAddress
- BranchAddress  out  Psize  PC load value
- ir_load  out  1  capture instruction into IR at end of cycle
- reg_we  out  1  register file write enable
- mul_start  out  1  one-cycle multiplier start pulse
- busy  out  1  high in FETCH, EXEC, MULW
- halted  out  1  high in HALTED
- error  out  1  sticky multiply-timeout flag
- retired  out  Csize  count of completed instructions, saturating

## Operation
- States: IDLE, FETCH, EXEC, MULW, HALTED. Reset state IDLE.
- Hold: PCup=0, BranchAddress=pc_in. Zero-pin: PCup=0, BranchAddress=0.
- Default outputs: PCup=0 with hold, ir_load=0, reg_we=0, mul_start=0.
- IDLE: zero-pin. start=1 -> FETCH; clear retired.
- FETCH: hold, ir_load=1 -> EXEC.
- EXEC, by opcode:
  - 000 NOP: PCup=1 -> FETCH.
  - 001 ADD, 010 ADDI: reg_we=1, PCup=1 -> FETCH.
  - 011 MUL: hold, mul_start=1, clear timeout counter -> MULW.
  - 100 BEQ: zero=1: PCup=0, BranchAddress=branch_target; zero=0: PCup=1. Both -> FETCH.
  - 101 JMP: PCup=0, BranchAddress=branch_target -> FETCH.
  - 110 reserved: treated as NOP.
  - 111 HALT: hold -> HALTED.
- MULW: mul_done=1: reg_we=1, PCup=1 -> FETCH. Otherwise hold and increment timeout counter. When the counter reaches MulTimeout with mul_done=0: set error, hold -> HALTED.
- HALTED: hold. start=1 -> IDLE-equivalent restart: zero-pin this cycle, clear error and retired -> FETCH.
- retired increments by 1 on each EXEC or MULW exit to FETCH, and on HALT. No increment on timeout. Saturates at 2^Csize-1.
- PC increment wrap from 2^Psize-1 to 0 is natural. No special handling; a NOP at the top address continues at 0.
- mul_done outside MULW is ignored.

## Timing
- PCup, BranchAddress, ir_load, reg_we and mul_start are combinational from state, opcode, zero and mul_done. State, counters and error are registered.
- Reset mid-operation: state returns to IDLE immediately. error=0, retired=0, timeout counter 0. Outputs settle combinationally to the IDLE values: PCup=0, BranchAddress=0, busy=0, halted=0. The PC register is reset by its own top-level reset.
- start to first ir_load: 1 cycle, because FETCH follows the start cycle.
- Simple instruction: 2 cycles (FETCH, EXEC). MUL: 3+N cycles, where N is the number of MULW cycles before mul_done. Minimum is 3, with mul_done in the first MULW cycle.
- Timeout: error asserts on the clock edge ending the MulTimeout-th MULW cycle without done.
- start is ignored in FETCH, EXEC and MULW.

## Test plan
- Reset and start: reset=1 -> all flags 0, PCup=0, BranchAddress=0. Release reset, start pulse -> FETCH with ir_load=1 next cycle, PC held at 0.
- Straight line: NOP, ADD, ADDI at 0..2 -> PC goes 0,0,1,1,2,2,3. reg_we=1 only in the ADD/ADDI EXEC cycles. retired=3.
- Branches: BEQ target 7 with zero=1 -> PC=7. BEQ target 7 with zero=0 -> PC+1. JMP target 31 -> PC=31. NOP at 31 -> PC wraps to 0.
- Multiply: MUL with mul_done after 4 MULW cycles -> mul_start one pulse, PC held 6 cycles total, then reg_we=1 with PCup=1. retired+1.
- Timeout: MUL with mul_done never asserted, MulTimeout=15 -> error=1 and halted=1 after 15 MULW cycles, PC unchanged, retired unchanged. start -> error=0, fetch from 0.
- HALT and async reset: HALT -> halted=1 and PC frozen for 10 cycles. Asserting reset mid-MULW -> immediate IDLE, error=0, retired=0.
